// File: rtl/digi_hockey_pkg.sv
// Shared types for the air-hockey core: FSM state codes, puck vertical direction, winner codes.
package digi_hockey_pkg;

   typedef enum logic [3:0] {
      IDLE_A  = 4'd0,
      IDLE_B  = 4'd1,
      SERVE_A = 4'd2,
      SERVE_B = 4'd3,
      MOVE_R  = 4'd4,
      MOVE_L  = 4'd5,
      RESP_A  = 4'd6,
      RESP_B  = 4'd7,
      GOAL_A  = 4'd8,
      GOAL_B  = 4'd9,
      OVER    = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      VD_NONE = 2'd0,
      VD_UP   = 2'd1,
      VD_DOWN = 2'd2
   } vdir_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_A    = 2'b01;
   localparam logic [1:0] WIN_B    = 2'b10;

   // Player shot encoding: 01 up, 10 down, 00/11 straight.
   function automatic vdir_t dir_to_vdir(input logic [1:0] dir);
      case (dir)
         2'b01:   return VD_UP;
         2'b10:   return VD_DOWN;
         default: return VD_NONE;
      endcase
   endfunction

endpackage

// File: rtl/digi_hockey_arena_if.sv
// Player controls in, puck/score/status out; master drives the controls, slave is the game core.
interface digi_hockey_arena_if #(
   parameter int CW = 3,
   parameter int SW = 2
);
   logic          BTN_A;
   logic          BTN_B;
   logic [1:0]    DIR_A;
   logic [1:0]    DIR_B;
   logic [CW-1:0] Y_IN_A;
   logic [CW-1:0] Y_IN_B;
   logic [CW-1:0] X_COORD;
   logic [CW-1:0] Y_COORD;
   logic [SW-1:0] SCORE_A;
   logic [SW-1:0] SCORE_B;
   logic [3:0]    STATE;
   logic          GOAL;
   logic [1:0]    WINNER;

   modport master (
      output BTN_A, BTN_B, DIR_A, DIR_B, Y_IN_A, Y_IN_B,
      input  X_COORD, Y_COORD, SCORE_A, SCORE_B, STATE, GOAL, WINNER
   );

   modport slave (
      input  BTN_A, BTN_B, DIR_A, DIR_B, Y_IN_A, Y_IN_B,
      output X_COORD, Y_COORD, SCORE_A, SCORE_B, STATE, GOAL, WINNER
   );
endinterface

// File: rtl/hockey_y_axis.sv
// Combinational one-step vertical puck update with reflection off rows 0 and Y_MAX.
module hockey_y_axis
   import digi_hockey_pkg::*;
#(
   parameter int CW    = 3,
   parameter int Y_MAX = 4
) (
   input  logic [CW-1:0] y,
   input  vdir_t         vdir,
   output logic [CW-1:0] y_nxt,
   output vdir_t         vdir_nxt
);
   localparam logic [CW-1:0] Y_TOP = CW'(Y_MAX);

   always_comb begin
      y_nxt    = y;
      vdir_nxt = vdir;
      case (vdir)
         VD_UP: begin
            if (y == Y_TOP) begin
               y_nxt    = Y_TOP - CW'(1);
               vdir_nxt = VD_DOWN;
            end else begin
               y_nxt = y + CW'(1);
            end
         end
         VD_DOWN: begin
            if (y == '0) begin
               y_nxt    = CW'(1);
               vdir_nxt = VD_UP;
            end else begin
               y_nxt = y - CW'(1);
            end
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/digi_hockey_arena.sv
// Two-player air-hockey game core: serve, move on ticks, return or concede, score, declare winner.
// Button presses act on the next clock edge; puck steps and response timeouts advance only on ticks.
module digi_hockey_arena
   import digi_hockey_pkg::*;
#(
   parameter int X_MAX      = 4,
   parameter int Y_MAX      = 4,
   parameter int CW         = 3,
   parameter int TICK_DIV   = 1,
   parameter int RESP_TICKS = 2,
   parameter int WIN_SCORE  = 3,
   parameter int SW         = 2
) (
   input logic                clk,
   input logic                rst,
   digi_hockey_arena_if.slave bus
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int RW = $clog2(RESP_TICKS + 1);

   localparam logic [CW-1:0] X_END     = CW'(X_MAX);
   localparam logic [CW-1:0] Y_TOP     = CW'(Y_MAX);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [RW-1:0] RESP_LAST = RW'(RESP_TICKS - 1);
   localparam logic [SW-1:0] SCORE_WIN = SW'(WIN_SCORE);

   state_t        state, state_nxt;
   logic [CW-1:0] x, x_nxt;
   logic [CW-1:0] y, y_nxt;
   vdir_t         vdir, vdir_nxt;
   logic [RW-1:0] resp_cnt, resp_nxt;
   logic [SW-1:0] score_a, score_a_nxt;
   logic [SW-1:0] score_b, score_b_nxt;
   logic [1:0]    winner, winner_nxt;
   logic [TW-1:0] tick_cnt;
   logic          tick;

   logic [CW-1:0] y_step;
   vdir_t         vdir_step;

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   hockey_y_axis #(
      .CW    (CW),
      .Y_MAX (Y_MAX)
   ) u_y_axis (
      .y        (y),
      .vdir     (vdir),
      .y_nxt    (y_step),
      .vdir_nxt (vdir_step)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE_A;
         x        <= '0;
         y        <= '0;
         vdir     <= VD_NONE;
         resp_cnt <= '0;
         score_a  <= '0;
         score_b  <= '0;
         winner   <= WIN_NONE;
      end else begin
         state    <= state_nxt;
         x        <= x_nxt;
         y        <= y_nxt;
         vdir     <= vdir_nxt;
         resp_cnt <= resp_nxt;
         score_a  <= score_a_nxt;
         score_b  <= score_b_nxt;
         winner   <= winner_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      x_nxt       = x;
      y_nxt       = y;
      vdir_nxt    = vdir;
      resp_nxt    = resp_cnt;
      score_a_nxt = score_a;
      score_b_nxt = score_b;
      winner_nxt  = winner;

      case (state)
         IDLE_A: begin
            if (bus.BTN_A && (bus.Y_IN_A <= Y_TOP)) begin
               state_nxt = SERVE_A;
               x_nxt     = '0;
               y_nxt     = bus.Y_IN_A;
               vdir_nxt  = dir_to_vdir(bus.DIR_A);
            end
         end
         IDLE_B: begin
            if (bus.BTN_B && (bus.Y_IN_B <= Y_TOP)) begin
               state_nxt = SERVE_B;
               x_nxt     = X_END;
               y_nxt     = bus.Y_IN_B;
               vdir_nxt  = dir_to_vdir(bus.DIR_B);
            end
         end
         // A serve is simply the first tick of the crossing.
         SERVE_A, MOVE_R: begin
            if (tick) begin
               x_nxt     = x + CW'(1);
               y_nxt     = y_step;
               vdir_nxt  = vdir_step;
               resp_nxt  = '0;
               state_nxt = (x_nxt == X_END) ? RESP_B : MOVE_R;
            end
         end
         SERVE_B, MOVE_L: begin
            if (tick) begin
               x_nxt     = x - CW'(1);
               y_nxt     = y_step;
               vdir_nxt  = vdir_step;
               resp_nxt  = '0;
               state_nxt = (x_nxt == '0) ? RESP_A : MOVE_L;
            end
         end
         RESP_A: begin
            if (bus.BTN_A) begin
               if (bus.Y_IN_A == y) begin
                  state_nxt = MOVE_R;
                  vdir_nxt  = dir_to_vdir(bus.DIR_A);
               end else begin
                  state_nxt = GOAL_B;
               end
            end else if (tick) begin
               if (resp_cnt == RESP_LAST) state_nxt = GOAL_B;
               else                       resp_nxt  = resp_cnt + RW'(1);
            end
         end
         RESP_B: begin
            if (bus.BTN_B) begin
               if (bus.Y_IN_B == y) begin
                  state_nxt = MOVE_L;
                  vdir_nxt  = dir_to_vdir(bus.DIR_B);
               end else begin
                  state_nxt = GOAL_A;
               end
            end else if (tick) begin
               if (resp_cnt == RESP_LAST) state_nxt = GOAL_A;
               else                       resp_nxt  = resp_cnt + RW'(1);
            end
         end
         GOAL_A: begin
            score_a_nxt = score_a + SW'(1);
            if (score_a_nxt == SCORE_WIN) begin
               state_nxt  = OVER;
               winner_nxt = WIN_A;
            end else begin
               state_nxt = IDLE_B;
            end
         end
         GOAL_B: begin
            score_b_nxt = score_b + SW'(1);
            if (score_b_nxt == SCORE_WIN) begin
               state_nxt  = OVER;
               winner_nxt = WIN_B;
            end else begin
               state_nxt = IDLE_A;
            end
         end
         OVER: begin
            if (bus.BTN_A && bus.BTN_B) begin
               score_a_nxt = '0;
               score_b_nxt = '0;
               winner_nxt  = WIN_NONE;
               state_nxt   = IDLE_A;
            end
         end
         default: state_nxt = IDLE_A;
      endcase
   end

   assign bus.X_COORD = x;
   assign bus.Y_COORD = y;
   assign bus.SCORE_A = score_a;
   assign bus.SCORE_B = score_b;
   assign bus.STATE   = state;
   assign bus.GOAL    = (state == GOAL_A) || (state == GOAL_B);
   assign bus.WINNER  = winner;
endmodule
